// File: rtl/mem_stage.sv
// MEM stage: holds one instruction, aligns load data for WB/ID, drops stale responses after a flush.
// Optional MEM_LWLR_EN: LWL/LWR produce partial-word data and byte-enable masks.
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 132,
  parameter int MS_TO_WS_BUS_WD = 126,
  parameter int MS_TO_DS_BUS_WD = 42
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic                       ws_allowin,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus,
  output logic                       ms_ex_eret,
  input  logic                       flush,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata
);

  localparam logic [2:0] OP_LB   = 3'd1;
  localparam logic [2:0] OP_LBU  = 3'd2;
  localparam logic [2:0] OP_LH   = 3'd3;
  localparam logic [2:0] OP_LHU  = 3'd4;
`ifdef MEM_LWLR_EN
  localparam logic [2:0] OP_LWL  = 3'd5;
  localparam logic [2:0] OP_LWR  = 3'd6;
`endif
  localparam logic [2:0] OP_NONE = 3'd7;

  logic                       ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] bus_r;
  logic                       buf_valid;
  logic [31:0]                buf_data;
  logic [1:0]                 discard_cnt;

  logic [2:0]  load_op;
  logic [1:0]  lo_addr;
  logic        mem_req;
  logic        data_ok_drop;
  logic        data_ok_own;
  logic        ms_ready_go;
  logic        ms_handoff;
  logic [31:0] rdata_sel;
  logic [31:0] shifted;
  logic [31:0] load_result;
  logic [31:0] result_out;
  logic [3:0]  rf_we_out;
  logic [2:0]  discard_inc;
  logic [2:0]  discard_sum;
  logic [1:0]  discard_next;

  assign load_op = bus_r[131:129];
  assign lo_addr = bus_r[128:127];
  assign mem_req = bus_r[126];

  // Stale responses always take precedence over the current instruction.
  assign data_ok_drop = data_sram_data_ok && (discard_cnt != 2'd0);
  assign data_ok_own  = data_sram_data_ok && (discard_cnt == 2'd0) && ms_valid && mem_req && !buf_valid;

  assign ms_ready_go    = !mem_req || buf_valid || data_ok_own;
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go && !flush;
  assign ms_handoff     = ms_to_ws_valid && ws_allowin;

  assign rdata_sel = buf_valid ? buf_data : data_sram_rdata;
  assign shifted   = rdata_sel >> {lo_addr, 3'b000};

  always_comb begin
    load_result = rdata_sel;
    rf_we_out   = bus_r[72:69];
    case (load_op)
      OP_LB:  load_result = {{24{shifted[7]}}, shifted[7:0]};
      OP_LBU: load_result = {24'd0, shifted[7:0]};
      OP_LH:  load_result = {{16{shifted[15]}}, shifted[15:0]};
      OP_LHU: load_result = {16'd0, shifted[15:0]};
`ifdef MEM_LWLR_EN
      OP_LWL: begin
        case (lo_addr)
          2'd0:    begin rf_we_out = 4'b1000; load_result = rdata_sel << 24; end
          2'd1:    begin rf_we_out = 4'b1100; load_result = rdata_sel << 16; end
          2'd2:    begin rf_we_out = 4'b1110; load_result = rdata_sel << 8;  end
          default: begin rf_we_out = 4'b1111; load_result = rdata_sel;       end
        endcase
      end
      OP_LWR: begin
        case (lo_addr)
          2'd0:    begin rf_we_out = 4'b1111; load_result = rdata_sel;       end
          2'd1:    begin rf_we_out = 4'b0111; load_result = rdata_sel >> 8;  end
          2'd2:    begin rf_we_out = 4'b0011; load_result = rdata_sel >> 16; end
          default: begin rf_we_out = 4'b0001; load_result = rdata_sel >> 24; end
        endcase
      end
`endif
      default: ;
    endcase
    result_out = (load_op == OP_NONE) ? bus_r[63:32] : load_result;
  end

  // Every request in flight at flush time still owes one data_ok that must be swallowed.
  always_comb begin
    discard_inc = 3'd0;
    if (flush) begin
      if (ms_valid && mem_req && !buf_valid && !data_ok_own) discard_inc = discard_inc + 3'd1;
      if (es_to_ms_valid && es_to_ms_bus[126])               discard_inc = discard_inc + 3'd1;
    end
    discard_sum  = {1'b0, discard_cnt} - {2'b00, data_ok_drop} + discard_inc;
    discard_next = (discard_sum > 3'd3) ? 2'd3 : discard_sum[1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid    <= 1'b0;
      bus_r       <= '0;
      buf_valid   <= 1'b0;
      buf_data    <= 32'd0;
      discard_cnt <= 2'd0;
    end else begin
      discard_cnt <= discard_next;
      if (flush) begin
        ms_valid  <= 1'b0;
        buf_valid <= 1'b0;
      end else begin
        if (ms_allowin) ms_valid <= es_to_ms_valid;
        if (es_to_ms_valid && ms_allowin) bus_r <= es_to_ms_bus;
        if (ms_handoff) begin
          buf_valid <= 1'b0;
        end else if (data_ok_own && !ws_allowin) begin
          buf_valid <= 1'b1;
          buf_data  <= data_sram_rdata;
        end
      end
    end
  end

  assign ms_to_ws_bus = {bus_r[125:73], rf_we_out, bus_r[68:64], result_out, bus_r[31:0]};
  assign ms_to_ds_bus = {ms_valid && (load_op != OP_NONE) && !ms_ready_go,
                         {4{ms_valid}} & rf_we_out, bus_r[68:64], result_out};
  assign ms_ex_eret   = ms_valid && (bus_r[78] || bus_r[90]);

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: driver pushes expected {rf_we,result,pc}, monitor pops on WB handoff.
module tb_mem_stage;

  logic         clk;
  logic         reset;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [131:0] es_to_ms_bus;
  logic         ws_allowin;
  logic         ms_to_ws_valid;
  logic [125:0] ms_to_ws_bus;
  logic [41:0]  ms_to_ds_bus;
  logic         ms_ex_eret;
  logic         flush;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;

  int checks = 0;
  int errors = 0;
  logic [67:0] exp_q[$];

  mem_stage dut (
    .clk(clk), .reset(reset), .ms_allowin(ms_allowin),
    .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
    .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid),
    .ms_to_ws_bus(ms_to_ws_bus), .ms_to_ds_bus(ms_to_ds_bus),
    .ms_ex_eret(ms_ex_eret), .flush(flush),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [131:0] mk(input logic [2:0] op, input logic [1:0] lo, input logic mr,
                                      input logic ex, input logic [3:0] we, input logic [31:0] res,
                                      input logic [31:0] pc);
    logic [131:0] b;
    b = '0;
    b[131:129] = op;
    b[128:127] = lo;
    b[126]     = mr;
    b[78]      = ex;
    b[72:69]   = we;
    b[68:64]   = 5'd3;
    b[63:32]   = res;
    b[31:0]    = pc;
    return b;
  endfunction

  task automatic push_exp(input logic [3:0] we, input logic [31:0] res, input logic [31:0] pc);
    exp_q.push_back({we, res, pc});
  endtask

  // Issue one instruction; MEM must be able to accept it.
  task automatic send(input logic [131:0] b);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = b;
    @(negedge clk);
    chk("send_allowin", {67'd0, ms_allowin}, 68'd1);
    @(posedge clk); #1;
    es_to_ms_valid = 1'b0;
  endtask

  task automatic resp(input logic [31:0] r);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = r;
    @(posedge clk); #1;
    data_sram_data_ok = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && ms_to_ws_valid && ws_allowin) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected actual=%h expected=none", ms_to_ws_bus[72:0]);
      end else begin
        chk("sb_wb_bus", {ms_to_ws_bus[72:69], ms_to_ws_bus[63:32], ms_to_ws_bus[31:0]},
            exp_q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0; ws_allowin = 1'b1;
    flush = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_allowin", {67'd0, ms_allowin}, 68'd1);
    chk("rst_ws_valid", {67'd0, ms_to_ws_valid}, 68'd0);
    chk("rst_ex_eret", {67'd0, ms_ex_eret}, 68'd0);
    chk("rst_ds_bus", {26'd0, ms_to_ds_bus}, 68'd0);
    @(posedge clk); #1;

    // LW with data_ok in its first MEM cycle
    push_exp(4'hF, 32'h12345678, 32'h100);
    send(mk(3'd0, 2'd0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h100));
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h12345678;
    @(negedge clk);
    chk("lw_same_cycle_valid", {67'd0, ms_to_ws_valid}, 68'd1);
    @(posedge clk); #1; data_sram_data_ok = 1'b0;

    // Byte/halfword alignment
    push_exp(4'hF, 32'hFFFFFF80, 32'h104);
    send(mk(3'd1, 2'd3, 1'b1, 1'b0, 4'hF, 32'h0, 32'h104)); resp(32'h80FF0000);
    push_exp(4'hF, 32'h00000080, 32'h108);
    send(mk(3'd2, 2'd3, 1'b1, 1'b0, 4'hF, 32'h0, 32'h108)); resp(32'h80FF0000);
    push_exp(4'hF, 32'h000080FF, 32'h10C);
    send(mk(3'd4, 2'd2, 1'b1, 1'b0, 4'hF, 32'h0, 32'h10C)); resp(32'h80FF0000);
    push_exp(4'hF, 32'hFFFF80FF, 32'h110);
    send(mk(3'd3, 2'd2, 1'b1, 1'b0, 4'hF, 32'h0, 32'h110)); resp(32'h80FF0000);
    // Non-load passes the EX result straight through
    push_exp(4'h5, 32'h0BADF00D, 32'h114);
    send(mk(3'd7, 2'd0, 1'b0, 1'b0, 4'h5, 32'h0BADF00D, 32'h114));

    // Response arrives while WB is stalled: must be buffered
    push_exp(4'hF, 32'hCAFEF00D, 32'h120);
    send(mk(3'd0, 2'd0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h120));
    ws_allowin = 1'b0;
    resp(32'hCAFEF00D);
    data_sram_rdata = 32'h11111111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("buf_valid_set", {67'd0, dut.buf_valid}, 68'd1);
      chk("buf_allowin_low", {67'd0, ms_allowin}, 68'd0);
      chk("buf_res_pending", {67'd0, ms_to_ds_bus[41]}, 68'd0);
      @(posedge clk); #1;
    end
    ws_allowin = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("buf_cleared", {67'd0, dut.buf_valid}, 68'd0);
    @(posedge clk); #1;

    // Flush while a load waits: its response must be dropped
    send(mk(3'd0, 2'd0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h200));
    @(negedge clk);
    chk("wait_res_pending", {67'd0, ms_to_ds_bus[41]}, 68'd1);
    flush = 1'b1;
    #1;
    chk("flush_no_wb", {67'd0, ms_to_ws_valid}, 68'd0);
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    chk("flush_ms_valid", {67'd0, dut.ms_valid}, 68'd0);
    chk("flush_discard1", {66'd0, dut.discard_cnt}, 68'd1);
    @(posedge clk); #1;
    resp(32'h0000DEAD);
    @(negedge clk);
    chk("discard_drained", {66'd0, dut.discard_cnt}, 68'd0);
    @(posedge clk); #1;
    push_exp(4'hF, 32'h0000BEEF, 32'h204);
    send(mk(3'd0, 2'd0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h204)); resp(32'h0000BEEF);

    // LWL / LWR
`ifdef MEM_LWLR_EN
    push_exp(4'b1100, 32'hCCDD0000, 32'h210);
    send(mk(3'd5, 2'd1, 1'b1, 1'b0, 4'hF, 32'h0, 32'h210)); resp(32'hAABBCCDD);
    push_exp(4'b0011, 32'h0000AABB, 32'h214);
    send(mk(3'd6, 2'd2, 1'b1, 1'b0, 4'hF, 32'h0, 32'h214)); resp(32'hAABBCCDD);
`else
    push_exp(4'hF, 32'hAABBCCDD, 32'h210);
    send(mk(3'd5, 2'd1, 1'b1, 1'b0, 4'hF, 32'h0, 32'h210)); resp(32'hAABBCCDD);
    push_exp(4'h6, 32'hAABBCCDD, 32'h214);
    send(mk(3'd6, 2'd2, 1'b1, 1'b0, 4'h6, 32'h0, 32'h214)); resp(32'hAABBCCDD);
`endif

    // Exception flag visible to EX while held in MEM
    ws_allowin = 1'b0;
    push_exp(4'h0, 32'h0, 32'h220);
    send(mk(3'd7, 2'd0, 1'b0, 1'b1, 4'h0, 32'h0, 32'h220));
    @(negedge clk);
    chk("ex_eret_flag", {67'd0, ms_ex_eret}, 68'd1);
    @(posedge clk); #1;
    ws_allowin = 1'b1;
    @(posedge clk); #1;

    // Two owed responses at flush, then reset mid-load
    send(mk(3'd0, 2'd0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h300));
    flush = 1'b1;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(3'd0, 2'd0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h304);
    @(posedge clk); #1;
    flush = 1'b0; es_to_ms_valid = 1'b0;
    @(negedge clk);
    chk("flush_discard2", {66'd0, dut.discard_cnt}, 68'd2);
    @(posedge clk); #1;
    send(mk(3'd0, 2'd0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h308));
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid_ms_valid", {67'd0, dut.ms_valid}, 68'd0);
    chk("rst_mid_discard", {66'd0, dut.discard_cnt}, 68'd0);
    chk("rst_mid_allowin", {67'd0, ms_allowin}, 68'd1);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    chk("sb_drained", 68'(exp_q.size()), 68'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage between exe_stage and wb_stage.
- Holds one instruction and waits for the SRAM-like data-bus response for loads issued in EX.
- Aligns and extends load data, then forwards the result to ID and hands a 126-bit bus to WB.
- After a WB exception or ERET flush, it tracks and discards stale data responses.

Parameters:
- ES_TO_MS_BUS_WD, 132, width of the EX->MEM bus.
- MS_TO_WS_BUS_WD, 126, width of the MEM->WB bus.
- MS_TO_DS_BUS_WD, 42, width of the forward/stall bus to ID.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- ms_allowin  out  1  MEM can accept from EX this cycle
- es_to_ms_valid  in  1  EX holds a valid instruction
- es_to_ms_bus  in  132  bit layout below
- ws_allowin  in  1  WB can accept
- ms_to_ws_valid  out  1  MEM output valid to WB
- ms_to_ws_bus  out  126  MEM->WB bus
- ms_to_ds_bus  out  42  {res_pending[41], rf_we[40:37], dest[36:32], result[31:0]}
- ms_ex_eret  out  1  valid MEM instruction has ex or eret; EX must suppress store requests
- flush  in  1  ws_ex | ws_eret from WB
- data_sram_data_ok  in  1  read/write response strobe
- data_sram_rdata  in  32  read data

Behaviour:
- Bit 131 of es_to_ms_bus is the MSB; field order from bit 131 down:
  - load_op[131:129]: 0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LWL, 6 LWR, 7 non-load.
  - lo_addr[128:127].
  - mem_req[126]: request was accepted in EX, so one data_ok is owed.
  - [125:0]: the WB bus layout. Bit 125 tlb_refill, 124 tlbwi, 123 tlbr, 122:91 badvaddr, 90:80 c0_bus (bit 90 eret), 79 bd, 78 ex, 77:73 excode, 72:69 rf_we, 68:64 dest, 63:32 result, 31:0 pc.
- EX never sets mem_req together with ex.
- ms_to_ws_bus equals bus_r[125:0], except:
  - result is replaced by aligned load data when load_op != 7;
  - rf_we is replaced by the LWL/LWR mask when that feature is enabled.
- Alignment, with sh = 8*lo_addr:
  - LB/LBU: byte (rdata>>sh)[7:0], sign- or zero-extended.
  - LH/LHU: halfword (rdata>>sh)[15:0], sign- or zero-extended.
  - LW: rdata.
- Registers and their reset values:
  - ms_valid = 0
  - bus_r = 0
  - buf_valid = 0
  - buf_data = 0
  - discard_cnt[1:0] = 0
- Outputs after reset: ms_allowin = 1, ms_to_ws_valid = 0, ms_ex_eret = 0, ms_to_ds_bus = 0.
- Data ownership:
  - data_ok with discard_cnt != 0 is consumed by the discard logic: discard_cnt decrements, MEM ignores it.
  - Otherwise data_ok belongs to the MEM instruction when ms_valid && mem_req && !buf_valid.
- Buffering: if MEM owns data_ok while ws_allowin = 0, latch rdata into buf_data and set buf_valid. buf_valid clears when MEM hands off to WB.
- Handshake:
  - ms_ready_go = !mem_req | buf_valid | (data_ok owned by MEM).
  - ms_allowin = !ms_valid | (ms_ready_go & ws_allowin).
  - ms_to_ws_valid = ms_valid & ms_ready_go & !flush.
- Load results use buf_data when buf_valid, else data_sram_rdata, i.e. zero extra latency when data_ok arrives in the first MEM cycle.
- Flush (priority over every other update):
  - ms_valid <= 0 and buf_valid <= 0.
  - If ms_valid && mem_req && !buf_valid && MEM did not own a data_ok this cycle, discard_cnt increments.
  - If es_to_ms_valid && es_to_ms_bus[126], discard_cnt also increments; EX-side cancellation is WB's job, but its owed response must still be dropped.
  - discard_cnt saturates at 3.
- Normal update: when ms_allowin, ms_valid <= es_to_ms_valid; bus_r loads on es_to_ms_valid && ms_allowin.
- Simultaneous data_ok and flush: data_ok is owned by MEM and is not counted for discard.
- ms_to_ds_bus:
  - res_pending = ms_valid & (load_op != 7) & !ms_ready_go.
  - rf_we field = {4{ms_valid}} & output rf_we.
- ms_ex_eret = ms_valid & (ex | eret).

Optional Feature:
- Macro MEM_LWLR_EN.
- Defined:
  - LWL by lo_addr 0..3: rf_we 1000/1100/1110/1111, data rdata<<24/<<16/<<8/rdata.
  - LWR by lo_addr 0..3: rf_we 1111/0111/0011/0001, data rdata/>>8/>>16/>>24.
- Undefined: load_op 5 and 6 behave as LW with rf_we from the bus.

Test Plan:
- LW with mem_req=1, data_ok in the first cycle with rdata=0x12345678, ws_allowin=1 -> ms_to_ws_valid=1 the same cycle, result=0x12345678.
- LB, lo_addr=3, rdata=0x80FF0000 -> result=0xFFFFFF80; LBU -> 0x00000080; LHU, lo_addr=2 -> 0x000080FF.
- data_ok arrives with ws_allowin=0 for 3 cycles -> buf_valid=1, ms_allowin=0, res_pending=0; WB receives the buffered data when ws_allowin rises.
- flush while a load waits (no data_ok) -> ms_valid=0, discard_cnt=1; next data_ok (rdata=0xDEAD) is dropped; a following LW receives its own data_ok with the correct value.
- MEM_LWLR_EN defined: LWL, lo_addr=1, rdata=0xAABBCCDD -> rf_we=1100, result=0xCCDD0000; LWR, lo_addr=2 -> rf_we=0011, result=0x0000AABB.
- reset asserted mid-load with discard_cnt=2 -> next cycle ms_valid=0, discard_cnt=0, ms_allowin=1.
